instr_fetch_stage: RTL and testbench



---
 rtl/instr_fetch_stage_pkg.sv | 39 +++
 rtl/instr_field_split.sv | 26 ++
 rtl/instr_fetch_stage.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared fetch-stage types: FSM states, instruction field positions,
// instruction width and default reset PC.
package instr_fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned JADDR_MSB  = 25;
    localparam int unsigned JADDR_LSB  = 0;

    localparam int unsigned OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned REG_W    = RS_MSB - RS_LSB + 1;
    localparam int unsigned SHAMT_W  = SHAMT_MSB - SHAMT_LSB + 1;
    localparam int unsigned FUNCT_W  = FUNCT_MSB - FUNCT_LSB + 1;
    localparam int unsigned IMM_W    = IMM_MSB - IMM_LSB + 1;
    localparam int unsigned JADDR_W  = JADDR_MSB - JADDR_LSB + 1;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicer of a MIPS instruction word into its fields;
// shared by the fetch stage and the decode/extend stage.
module instr_field_split
    import instr_fetch_stage_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic [IMM_W-1:0]    imm16,
    output logic [JADDR_W-1:0]  jaddr
);

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16  = instr[IMM_MSB:IMM_LSB];
    assign jaddr  = instr[JADDR_MSB:JADDR_LSB];

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS fetch stage: PC, single-outstanding imem req/ack, instruction register.
// Optional misaligned-redirect trap enabled by macro IF_MISALIGN_TRAP_EN.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic                instr_valid_o,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [ADDR_W-1:0]   pc_plus4_o,
    output logic [OPCODE_W-1:0] opcode_o,
    output logic [REG_W-1:0]    rs_o,
    output logic [REG_W-1:0]    rt_o,
    output logic [REG_W-1:0]    rd_o,
    output logic [SHAMT_W-1:0]  shamt_o,
    output logic [FUNCT_W-1:0]  funct_o,
    output logic [IMM_W-1:0]    imm16_o,
    output logic [JADDR_W-1:0]  jaddr_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                misalign_o
`endif
);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  drain_addr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               take_redir;
    logic               halt_pend;
    logic [ADDR_W-1:0]  redir_target;

    assign redir_target = redirect_pc_i & ~ADDR_W'(3);

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign;
    logic trap;
    // Once trapped (or halted) all further redirects are ignored.
    assign take_redir = redirect_i && !misalign && (state != ST_HALT);
    assign trap       = take_redir && (redirect_pc_i[1:0] != 2'b00);
    assign halt_pend  = trap || misalign;
    assign misalign_o = misalign;
`else
    assign take_redir = redirect_i;
    assign halt_pend  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_REQ;
        else       state <= state_next;
    end

    // Next-state logic; redirect outranks ack and stall
    always_comb begin
        state_next = state;
        unique case (state)
            ST_REQ: begin
                if (take_redir) begin
                    if (!imem_ack_i)   state_next = ST_DRAIN;
                    else if (halt_pend) state_next = ST_HALT;
                    else               state_next = ST_REQ;
                end else if (imem_ack_i) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (take_redir)
                    state_next = halt_pend ? ST_HALT : ST_REQ;
                else if (!stall_i)
                    state_next = ST_REQ;
            end
            ST_DRAIN: begin
                // The stale reply closes the old request; refetch at pc.
                if (imem_ack_i)
                    state_next = halt_pend ? ST_HALT : ST_REQ;
            end
            ST_HALT: state_next = ST_HALT;
        endcase
    end

    // Memory-side outputs; DRAIN keeps presenting the abandoned address
    always_comb begin
        imem_req_o  = (state == ST_REQ) || (state == ST_DRAIN);
        imem_addr_o = (state == ST_DRAIN) ? drain_addr : pc;
    end

    // PC, drain address and instruction register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            instr_pc   <= '0;
            instr      <= '0;
            valid      <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else if (take_redir) begin
            pc    <= redir_target;
            valid <= 1'b0;
            if (state == ST_REQ && !imem_ack_i)
                drain_addr <= pc;
`ifdef IF_MISALIGN_TRAP_EN
            if (trap) misalign <= 1'b1;
`endif
        end else if (state == ST_REQ && imem_ack_i) begin
            instr    <= imem_rdata_i;
            instr_pc <= pc;
            valid    <= 1'b1;
            pc       <= pc + ADDR_W'(4);
        end else if (state == ST_HOLD && !stall_i) begin
            valid <= 1'b0;
        end
    end

    assign instr_valid_o = valid;
    assign instr_o       = instr;
    assign pc_o          = instr_pc;
    assign pc_plus4_o    = instr_pc + ADDR_W'(4);

    instr_field_split u_split (
        .instr  (instr),
        .opcode (opcode_o),
        .rs     (rs_o),
        .rt     (rt_o),
        .rd     (rd_o),
        .shamt  (shamt_o),
        .funct  (funct_o),
        .imm16  (imm16_o),
        .jaddr  (jaddr_o)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed steps, then random
// traffic against a transaction-level model of the fetch rules.
module tb_instr_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [5:0]  opcode_o;
    logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
    logic [5:0]  funct_o;
    logic [15:0] imm16_o;
    logic [25:0] jaddr_o;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    // Model: a fetch is pending whenever no instruction is held; a
    // redirect without ack leaves a "killed" request whose reply is dropped.
    bit          m_valid;
    bit          m_kill;
    logic [31:0] m_pc, m_kill_addr, m_instr, m_ipc;

    instr_fetch_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .opcode_o      (opcode_o),
        .rs_o          (rs_o),
        .rt_o          (rt_o),
        .rd_o          (rd_o),
        .shamt_o       (shamt_o),
        .funct_o       (funct_o),
        .imm16_o       (imm16_o),
        .jaddr_o       (jaddr_o)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("req", 32'(imem_req_o), 32'(!m_valid));
        if (!m_valid)
            check("addr", imem_addr_o, m_kill ? m_kill_addr : m_pc);
        check("valid", 32'(instr_valid_o), 32'(m_valid));
        check("instr", instr_o, m_instr);
        check("pc_o", pc_o, m_ipc);
        check("pc_plus4", pc_plus4_o, m_ipc + 32'd4);
        check("opcode", 32'(opcode_o), 32'(m_instr >> 26));
        check("rs", 32'(rs_o), (m_instr >> 21) & 32'h1F);
        check("rt", 32'(rt_o), (m_instr >> 16) & 32'h1F);
        check("rd", 32'(rd_o), (m_instr >> 11) & 32'h1F);
        check("shamt", 32'(shamt_o), (m_instr >> 6) & 32'h1F);
        check("funct", 32'(funct_o), m_instr & 32'h3F);
        check("imm16", 32'(imm16_o), m_instr & 32'hFFFF);
        check("jaddr", 32'(jaddr_o), m_instr & 32'h03FF_FFFF);
    endtask

    task automatic model_step(input bit ack, input logic [31:0] rdata,
                              input bit stall, input bit redir,
                              input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (m_valid) begin
            if (redir) begin
                m_pc = t;
                m_valid = 0;
            end else if (!stall) begin
                m_valid = 0;
            end
        end else if (ack) begin
            if (redir) begin
                m_pc = t;
                m_kill = 0;
            end else if (m_kill) begin
                m_kill = 0;
            end else begin
                m_instr = rdata;
                m_ipc = m_pc;
                m_valid = 1;
                m_pc = m_pc + 32'd4;
            end
        end else if (redir) begin
            if (!m_kill) begin
                m_kill = 1;
                m_kill_addr = m_pc;
            end
            m_pc = t;
        end
    endtask

    task automatic cycle(input bit ack, input logic [31:0] rdata,
                         input bit stall, input bit redir,
                         input logic [31:0] tgt);
        bit a;
        a = ack && !m_valid;
        imem_ack_i = a;
        imem_rdata_i = rdata;
        stall_i = stall;
        redirect_i = redir;
        redirect_pc_i = tgt;
        @(posedge clk_i);
        model_step(a, rdata, stall, redir, tgt);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        imem_ack_i = 1'b0;
        m_valid = 0;
        m_kill = 0;
        m_pc = 32'h0;
        m_kill_addr = 32'h0;
        m_instr = 32'h0;
        m_ipc = 32'h0;
    endtask

    initial begin
        bit ack, stall, redir;
        logic [31:0] tgt;

        // Reset with an ack present: it must be ignored
        do_reset(2);
        check_all();
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_pc_plus4", pc_plus4_o, 32'h4);

        // First fetch, ack one cycle after req, then consume
        cycle(0, 32'h0, 0, 0, 32'h0);
        cycle(1, 32'h0123_4567, 1, 0, 32'h0);
        check("first_valid", 32'(instr_valid_o), 32'h1);
        check("first_pc", pc_o, 32'h0);
        check("first_instr", instr_o, 32'h0123_4567);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("second_addr", imem_addr_o, 32'h4);

        // addi with a stalled consumer for 5 cycles
        cycle(1, 32'h2008_FFFC, 1, 0, 32'h0);
        check("addi_opcode", 32'(opcode_o), 32'h08);
        check("addi_rs", 32'(rs_o), 32'h0);
        check("addi_rt", 32'(rt_o), 32'h8);
        check("addi_imm", 32'(imm16_o), 32'hFFFC);
        repeat (5) cycle(0, 32'h0, 1, 0, 32'h0);
        check("stall_valid", 32'(instr_valid_o), 32'h1);
        check("stall_instr", instr_o, 32'h2008_FFFC);
        cycle(0, 32'h0, 0, 0, 32'h0);

        // Redirect while a request is outstanding, ack 3 cycles later
        cycle(0, 32'h0, 0, 1, 32'h0000_0100);
        check("drain_addr", imem_addr_o, 32'h8);
        cycle(0, 32'h0, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("drain_addr2", imem_addr_o, 32'h8);
        cycle(1, 32'hBAD0_BAD0, 0, 0, 32'h0);
        check("drain_novalid", 32'(instr_valid_o), 32'h0);
        check("after_drain", imem_addr_o, 32'h100);

        // Redirect and ack in the same cycle
        cycle(1, 32'hBAD1_BAD1, 0, 1, 32'h0000_0200);
        check("redir_ack_valid", 32'(instr_valid_o), 32'h0);
        check("redir_ack_addr", imem_addr_o, 32'h200);

        // Wrap at the top of the address space
        cycle(1, 32'h0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 32'h8C00_0000, 0, 0, 32'h0);
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4_o, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0);
        check("wrap_addr", imem_addr_o, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ack   = ($urandom_range(0, 99) < 45);
            stall = ($urandom_range(0, 99) < 40);
            redir = ($urandom_range(0, 99) < 12);
            tgt   = $urandom;
            if ($urandom_range(0, 9) == 0)
                tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef IF_MISALIGN_TRAP_EN
            tgt = tgt & ~32'h3;
`endif
            cycle(ack, $urandom, stall, redir, tgt);
        end

`ifdef IF_MISALIGN_TRAP_EN
        do_reset(1);
        check("mis_rst", 32'(misalign_o), 32'h0);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(posedge clk_i);
        #1;
        redirect_i = 1'b0;
        check("mis_set", 32'(misalign_o), 32'h1);
        check("mis_drain_req", 32'(imem_req_o), 32'h1);
        check("mis_drain_addr", imem_addr_o, 32'h0);
        imem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        imem_ack_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        repeat (3) @(posedge clk_i);
        #1;
        redirect_i = 1'b0;
        check("halt_req", 32'(imem_req_o), 32'h0);
        check("halt_valid", 32'(instr_valid_o), 32'h0);
        check("halt_sticky", 32'(misalign_o), 32'h1);
        do_reset(1);
        check("mis_clr", 32'(misalign_o), 32'h0);
        check("mis_req", 32'(imem_req_o), 32'h1);
        check("mis_addr", imem_addr_o, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
